// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, encodings and width helpers for the direct-mapped data cache
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } dc_state_t;

  localparam logic [1:0] MT_BYTE = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_WORD = 2'b10;

  localparam int OFF_BITS = 2;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int word_bits(input int line_words);
    return log2_ceil(line_words);
  endfunction

  function automatic int set_bits(input int sets);
    return log2_ceil(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
    return addr_w - OFF_BITS - set_bits(sets) - word_bits(line_words);
  endfunction

endpackage

// File: rtl/load_ext_unit.sv
// rtl/load_ext_unit.sv - byte/half/word lane select with sign or zero extension
module load_ext_unit
  import dcache_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic        zext_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (type_i)
      MT_BYTE: data_o = {{24{~zext_i & byte_sel[7]}}, byte_sel};
      MT_HALF: data_o = {{16{~zext_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through no-write-allocate data cache for the memory stage
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [ADDR_WIDTH-1:0] Addr_i,
  input  logic [DATA_WIDTH-1:0] WriteData_i,
  input  logic [1:0]            MemType_i,
  input  logic                  MemSign_i,
  output logic [DATA_WIDTH-1:0] ReadData_o,
  output logic                  Stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int WORD_W = word_bits(LINE_WORDS);
  localparam int SET_W  = set_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, SETS, LINE_WORDS);

  dc_state_t state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [SETS-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

  logic [WORD_W-1:0] word_idx;
  logic [SET_W-1:0]  set_idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              fill_we, merge_we, tag_we;
  logic [3:0]        st_strb;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] ld_data;

  assign word_idx = Addr_i[OFF_BITS +: WORD_W];
  assign set_idx  = Addr_i[OFF_BITS+WORD_W +: SET_W];
  assign tag      = Addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign hit      = valid_q[set_idx] && (tag_q[set_idx] == tag);

  // Store lanes: strobes follow natural alignment, data is replicated so any lane sees it
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = WriteData_i;
    case (MemType_i)
      MT_BYTE: begin
        st_strb  = 4'b0001 << Addr_i[1:0];
        st_wdata = {4{WriteData_i[7:0]}};
      end
      MT_HALF: begin
        st_strb  = Addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WriteData_i[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = WriteData_i;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    Stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = 4'b0000;
    fill_we     = 1'b0;
    merge_we    = 1'b0;
    tag_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemWrite_i) begin
          Stall_o = 1'b1;
          state_d = ST_WRITE;
        end else if (MemRead_i && !hit) begin
          Stall_o = 1'b1;
          cnt_d   = '0;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        Stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {Addr_i[ADDR_WIDTH-1:OFF_BITS+WORD_W], cnt_q, 2'b00};
        if (mem_ack_i) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + WORD_W'(1);
          if (cnt_q == {WORD_W{1'b1}}) begin
            tag_we           = 1'b1;
            valid_d[set_idx] = 1'b1;
            state_d          = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        // Dropping the stall in the ack cycle lets the pipeline retire the store exactly once
        Stall_o     = ~mem_ack_i;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {Addr_i[ADDR_WIDTH-1:OFF_BITS], 2'b00};
        mem_wdata_o = st_wdata;
        mem_wstrb_o = st_strb;
        if (mem_ack_i) begin
          merge_we = hit;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_q[set_idx][cnt_q] <= mem_rdata_i;
    if (merge_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_strb[b]) data_q[set_idx][word_idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
    if (tag_we) tag_q[set_idx] <= tag;
  end

  load_ext_unit u_load_ext (
    .word_i (data_q[set_idx][word_idx]),
    .off_i  (Addr_i[1:0]),
    .type_i (MemType_i),
    .zext_i (MemSign_i),
    .data_o (ld_data)
  );

  assign ReadData_o = (state_q == ST_IDLE && MemRead_i && !MemWrite_i && hit) ? ld_data : '0;

endmodule
